reduce_engine: RTL and testbench

//  Parametrised successor reduction unit for the collective router. Accumulates reduction flits
//  (op[3:2]==2'b11) per tag-indexed table entry until all children plus the local contribution

---
 rtl/reduce_pkg.sv | 39 +++
 rtl/reduce_alu.sv | 63 ++++++
 rtl/reduce_engine.sv | 151 +++++++++++++++
 tb/tb_reduce_engine.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// Shared definitions for the collective-router reduction engine: flit header layout
// (offsets relative to the payload top), opcodes, ALU encodings and table entry states.
package reduce_pkg;

    // Header fields sit directly above the payload; valid bit is the flit MSB.
    localparam int OP_W    = 4;
    localparam int ALG_W   = 2;
    localparam int TAG_W   = 8;
    localparam int CTX_W   = 8;
    localparam int DST_W   = 8;
    localparam int OP_LSB  = 0;
    localparam int ALG_LSB = OP_LSB + OP_W;
    localparam int TAG_LSB = ALG_LSB + ALG_W;
    localparam int CTX_LSB = TAG_LSB + TAG_W;
    localparam int DST_LSB = CTX_LSB + CTX_W;
    localparam int VLD_LSB = DST_LSB + DST_W;
    localparam int HDR_W   = VLD_LSB + 1;

    localparam logic [1:0] RED_OP_CLASS = 2'b11;

    typedef enum logic [1:0] {
        ALG_ADD = 2'b00,
        ALG_MAX = 2'b01,
        ALG_MIN = 2'b10,
        ALG_OR  = 2'b11
    } alg_e;

    typedef enum logic [1:0] {
        ENT_FREE,
        ENT_ACCUM,
        ENT_BUSY,
        ENT_DONE
    } entry_state_e;

    function automatic logic is_reduction(input logic vld, input logic [OP_W-1:0] op);
        return vld && (op[3:2] == RED_OP_CLASS);
    endfunction

endpackage

// File: rtl/reduce_alu.sv
// Shared reduction ALU: combinational op feeding an AluLatency-deep register pipeline
// that carries the owning table index alongside the result.
module reduce_alu
    import reduce_pkg::*;
#(
    parameter int PayloadWidth = 32,
    parameter int IdxWidth     = 2,
    parameter int AluLatency   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [IdxWidth-1:0]     issue_idx,
    input  logic [PayloadWidth-1:0] op_a,
    input  logic [PayloadWidth-1:0] op_b,
    input  alg_e                    alg,
    output logic                    wb_valid,
    output logic [IdxWidth-1:0]     wb_idx,
    output logic [PayloadWidth-1:0] wb_result,
    output logic                    pipe_busy
);

    logic [PayloadWidth-1:0] result;
    logic [AluLatency-1:0]   stage_valid;
    logic [IdxWidth-1:0]     stage_idx [AluLatency];
    logic [PayloadWidth-1:0] stage_res [AluLatency];

    always_comb begin
        result = op_a + op_b;
        case (alg)
            ALG_ADD: result = op_a + op_b;
            ALG_MAX: result = ($signed(op_a) > $signed(op_b)) ? op_a : op_b;
            ALG_MIN: result = ($signed(op_a) < $signed(op_b)) ? op_a : op_b;
            ALG_OR:  result = op_a | op_b;
            default: result = op_a + op_b;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_valid <= '0;
            for (int i = 0; i < AluLatency; i++) begin
                stage_idx[i] <= '0;
                stage_res[i] <= '0;
            end
        end else begin
            stage_valid[0] <= issue_valid;
            stage_idx[0]   <= issue_idx;
            stage_res[0]   <= result;
            for (int i = 1; i < AluLatency; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_idx[i]   <= stage_idx[i-1];
                stage_res[i]   <= stage_res[i-1];
            end
        end
    end

    assign wb_valid  = stage_valid[AluLatency-1];
    assign wb_idx    = stage_idx[AluLatency-1];
    assign wb_result = stage_res[AluLatency-1];
    assign pipe_busy = |stage_valid;

endmodule

// File: rtl/reduce_engine.sv
// Reduction engine: tag-indexed table accumulating child contributions through the shared
// ALU, emitting one combined flit per entry via a round-robin output register.
module reduce_engine
    import reduce_pkg::*;
#(
    parameter int PayloadWidth  = 32,
    parameter int lg_numprocs   = 3,
    parameter int lg_TableDepth = 2,
    parameter int AluLatency    = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [PayloadWidth+HDR_W+lg_numprocs-1:0] in_flit,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [PayloadWidth+HDR_W-1:0]             out_flit,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      ctx_err,
    output logic                                      busy
);

    localparam int FlitWidth  = PayloadWidth + HDR_W;
    localparam int TableDepth = 1 << lg_TableDepth;

    entry_state_e            state_q     [TableDepth];
    logic [HDR_W-1:0]        hdr_q       [TableDepth];
    logic [PayloadWidth-1:0] acc_q       [TableDepth];
    logic [lg_numprocs-1:0]  remaining_q [TableDepth];

    logic [lg_numprocs-1:0]   in_children;
    logic [HDR_W-1:0]         in_hdr;
    logic [PayloadWidth-1:0]  in_payload;
    logic [lg_TableDepth-1:0] in_idx;
    logic                     is_red;
    logic                     ctx_eq;
    logic                     accept;
    logic                     issue;
    logic                     ctx_mismatch;

    logic                     wb_valid;
    logic [lg_TableDepth-1:0] wb_idx;
    logic [PayloadWidth-1:0]  wb_result;
    logic                     pipe_busy;

    logic [lg_TableDepth-1:0] rr_ptr;
    logic [lg_TableDepth-1:0] cand;
    logic [lg_TableDepth-1:0] grant_idx;
    logic                     grant_found;
    logic                     grant;

    assign {in_children, in_hdr, in_payload} = in_flit;
    assign in_idx       = in_hdr[TAG_LSB +: lg_TableDepth];
    assign is_red       = is_reduction(in_hdr[VLD_LSB], in_hdr[OP_LSB +: OP_W]);
    assign ctx_eq       = hdr_q[in_idx][CTX_LSB +: CTX_W] == in_hdr[CTX_LSB +: CTX_W];
    assign in_ready     = !is_red || !(state_q[in_idx] == ENT_BUSY || state_q[in_idx] == ENT_DONE);
    assign accept       = in_valid && in_ready && is_red;
    assign issue        = accept && (state_q[in_idx] == ENT_ACCUM) && ctx_eq;
    assign ctx_mismatch = accept && (state_q[in_idx] == ENT_ACCUM) && !ctx_eq;

    reduce_alu #(
        .PayloadWidth(PayloadWidth),
        .IdxWidth    (lg_TableDepth),
        .AluLatency  (AluLatency)
    ) u_alu (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue),
        .issue_idx  (in_idx),
        .op_a       (acc_q[in_idx]),
        .op_b       (in_payload),
        .alg        (alg_e'(hdr_q[in_idx][ALG_LSB +: ALG_W])),
        .wb_valid   (wb_valid),
        .wb_idx     (wb_idx),
        .wb_result  (wb_result),
        .pipe_busy  (pipe_busy)
    );

    // Round-robin search for a DONE entry, starting at the slot after the last grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < TableDepth; k++) begin
            cand = rr_ptr + lg_TableDepth'(k);
            if (!grant_found && state_q[cand] == ENT_DONE) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant = grant_found && (!out_valid || out_ready);

    // Accept, writeback and grant always touch distinct entries, so they never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TableDepth; i++) begin
                state_q[i]     <= ENT_FREE;
                hdr_q[i]       <= '0;
                acc_q[i]       <= '0;
                remaining_q[i] <= '0;
            end
        end else begin
            if (accept && state_q[in_idx] == ENT_FREE) begin
                hdr_q[in_idx]       <= in_hdr;
                acc_q[in_idx]       <= in_payload;
                remaining_q[in_idx] <= in_children;
                state_q[in_idx]     <= (in_children == '0) ? ENT_DONE : ENT_ACCUM;
            end else if (issue) begin
                state_q[in_idx] <= ENT_BUSY;
            end
            if (wb_valid) begin
                acc_q[wb_idx]       <= wb_result;
                remaining_q[wb_idx] <= remaining_q[wb_idx] - lg_numprocs'(1);
                state_q[wb_idx]     <= (remaining_q[wb_idx] == lg_numprocs'(1)) ? ENT_DONE : ENT_ACCUM;
            end
            if (grant) begin
                state_q[grant_idx] <= ENT_FREE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_flit  <= '0;
            rr_ptr    <= '0;
            ctx_err   <= 1'b0;
        end else begin
            ctx_err <= ctx_mismatch;
            if (grant) begin
                out_valid <= 1'b1;
                out_flit  <= {hdr_q[grant_idx], acc_q[grant_idx]};
                rr_ptr    <= grant_idx + lg_TableDepth'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        busy = pipe_busy;
        for (int i = 0; i < TableDepth; i++) begin
            if (state_q[i] != ENT_FREE) begin
                busy = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reduce_engine.sv
// Directed self-checking bench for reduce_engine with hand-computed expected flits.
module tb_reduce_engine;

    localparam int ALU_LAT = 4;
    localparam logic [3:0] RED = 4'b1100;

    logic        clk;
    logic        rst;
    logic [65:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic [62:0] out_flit;
    logic        out_valid;
    logic        out_ready;
    logic        ctx_err;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    reduce_engine #(
        .PayloadWidth (32),
        .lg_numprocs  (3),
        .lg_TableDepth(2),
        .AluLatency   (ALU_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_flit  (in_flit),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_flit (out_flit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ctx_err  (ctx_err),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [65:0] mkFlit(input logic [2:0] ch, input logic [7:0] dst,
                                           input logic [7:0] ctx, input logic [7:0] tag,
                                           input logic [1:0] alg, input logic [3:0] op,
                                           input logic [31:0] pl);
        return {ch, 1'b1, dst, ctx, tag, alg, op, pl};
    endfunction

    function automatic logic [62:0] mkOut(input logic [7:0] dst, input logic [7:0] ctx,
                                          input logic [7:0] tag, input logic [1:0] alg,
                                          input logic [31:0] acc);
        return {1'b1, dst, ctx, tag, alg, RED, acc};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [65:0] f);
        int n;
        n = 0;
        @(negedge clk);
        in_flit  = f;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic probeReady(input string tag, input logic [7:0] t, input logic exp);
        in_valid = 1'b0;
        in_flit  = mkFlit(3'd0, 8'h00, 8'h00, t, 2'b00, RED, 32'h0);
        #1;
        checkOutput(tag, 64'(in_ready), 64'(exp));
    endtask

    task automatic expectOut(input string tag, input logic [62:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_flit"}, 64'(out_flit), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [65:0] f;
        rst       = 1'b0;
        in_flit   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #12;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_flit", 64'(out_flit), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_ctx_err", 64'(ctx_err), 64'd0);
        probeReady("rst_in_ready", 8'd1, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // Leaf: DONE at accept edge, output valid one edge later.
        applyStimulus(mkFlit(3'd0, 8'hA1, 8'h22, 8'd5, 2'b00, RED, 32'h10));
        checkOutput("leaf_busy", 64'(busy), 64'd1);
        checkOutput("leaf_early", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("leaf_valid", 64'(out_valid), 64'd1);
        checkOutput("leaf_flit", 64'(out_flit), 64'(mkOut(8'hA1, 8'h22, 8'd5, 2'b00, 32'h10)));
        @(posedge clk);
        #1;

        // Sum of four contributions.
        applyStimulus(mkFlit(3'd3, 8'h10, 8'h55, 8'd2, 2'b00, RED, 32'd5));
        applyStimulus(mkFlit(3'd0, 8'h10, 8'h55, 8'd2, 2'b00, RED, 32'd1));
        probeReady("sum_busy_ready", 8'd2, 1'b0);
        probeReady("sum_other_ready", 8'd1, 1'b1);
        applyStimulus(mkFlit(3'd0, 8'h10, 8'h55, 8'd2, 2'b00, RED, 32'd2));
        applyStimulus(mkFlit(3'd0, 8'h10, 8'h55, 8'd2, 2'b00, RED, 32'd3));
        expectOut("sum4", mkOut(8'h10, 8'h55, 8'd2, 2'b00, 32'hB));

        // Signed max with exact single-child latency.
        applyStimulus(mkFlit(3'd1, 8'h01, 8'h07, 8'd0, 2'b01, RED, 32'hFFFF_FFFE));
        applyStimulus(mkFlit(3'd0, 8'h01, 8'h07, 8'd0, 2'b01, RED, 32'h3));
        repeat (ALU_LAT) @(posedge clk);
        #1;
        checkOutput("max_early", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("max_valid", 64'(out_valid), 64'd1);
        checkOutput("max_flit", 64'(out_flit), 64'(mkOut(8'h01, 8'h07, 8'd0, 2'b01, 32'h3)));
        @(posedge clk);
        #1;

        applyStimulus(mkFlit(3'd1, 8'h02, 8'h08, 8'd1, 2'b10, RED, 32'hFFFF_FFFE));
        applyStimulus(mkFlit(3'd0, 8'h02, 8'h08, 8'd1, 2'b10, RED, 32'h3));
        expectOut("min", mkOut(8'h02, 8'h08, 8'd1, 2'b10, 32'hFFFF_FFFE));

        applyStimulus(mkFlit(3'd1, 8'h03, 8'h09, 8'd2, 2'b11, RED, 32'hF0));
        applyStimulus(mkFlit(3'd0, 8'h03, 8'h09, 8'd2, 2'b11, RED, 32'h0F));
        expectOut("or", mkOut(8'h03, 8'h09, 8'd2, 2'b11, 32'hFF));

        // Context mismatch leaves the accumulation untouched.
        applyStimulus(mkFlit(3'd1, 8'h09, 8'h12, 8'd3, 2'b00, RED, 32'h100));
        applyStimulus(mkFlit(3'd0, 8'h09, 8'h34, 8'd3, 2'b00, RED, 32'h999));
        checkOutput("ctx_err_pulse", 64'(ctx_err), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("ctx_err_clear", 64'(ctx_err), 64'd0);
        checkOutput("ctx_no_out", 64'(out_valid), 64'd0);
        applyStimulus(mkFlit(3'd0, 8'h09, 8'h12, 8'd3, 2'b00, RED, 32'h1));
        expectOut("ctx_result", mkOut(8'h09, 8'h12, 8'd3, 2'b00, 32'h101));

        // Non-reduction and invalid flits are swallowed.
        applyStimulus(mkFlit(3'd0, 8'h04, 8'h04, 8'd1, 2'b00, 4'b0100, 32'h44));
        f = mkFlit(3'd0, 8'h05, 8'h05, 8'd1, 2'b00, RED, 32'h55);
        f[62] = 1'b0;
        applyStimulus(f);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("drop_out_valid", 64'(out_valid), 64'd0);
        checkOutput("drop_busy", 64'(busy), 64'd0);

        // Back-pressure: output full, two DONE entries wait, round robin 0 then 2.
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(mkFlit(3'd0, 8'h33, 8'h03, 8'd3, 2'b00, RED, 32'h33));
        applyStimulus(mkFlit(3'd0, 8'hA0, 8'h00, 8'd0, 2'b00, RED, 32'hA0));
        applyStimulus(mkFlit(3'd0, 8'hC0, 8'h02, 8'd2, 2'b00, RED, 32'hC0));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp_first", 64'(out_flit), 64'(mkOut(8'h33, 8'h03, 8'd3, 2'b00, 32'h33)));
        probeReady("bp_ready_idx0", 8'd0, 1'b0);
        probeReady("bp_ready_idx2", 8'd2, 1'b0);
        probeReady("bp_ready_idx1", 8'd1, 1'b1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_grant0", 64'(out_flit), 64'(mkOut(8'hA0, 8'h00, 8'd0, 2'b00, 32'hA0)));
        @(negedge clk);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp_hold0_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_hold0", 64'(out_flit), 64'(mkOut(8'hA0, 8'h00, 8'd0, 2'b00, 32'hA0)));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_grant2", 64'(out_flit), 64'(mkOut(8'hC0, 8'h02, 8'd2, 2'b00, 32'hC0)));
        @(posedge clk);
        #1;
        checkOutput("bp_drained", 64'(out_valid), 64'd0);

        // Reset in the middle of an ALU operation discards everything.
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(mkFlit(3'd0, 8'h77, 8'h00, 8'd0, 2'b00, RED, 32'h77));
        applyStimulus(mkFlit(3'd1, 8'h11, 8'h01, 8'd1, 2'b00, RED, 32'h4));
        applyStimulus(mkFlit(3'd0, 8'h11, 8'h01, 8'd1, 2'b00, RED, 32'h5));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_out_flit", 64'(out_flit), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) probeReady($sformatf("post_rst_ready%0d", i), 8'(i), 1'b1);
        applyStimulus(mkFlit(3'd0, 8'h66, 8'h06, 8'd1, 2'b00, RED, 32'h5));
        expectOut("post_rst_leaf", mkOut(8'h66, 8'h06, 8'd1, 2'b00, 32'h5));
        repeat (ALU_LAT + 3) @(posedge clk);
        #1;
        checkOutput("post_rst_no_stale", 64'(out_valid), 64'd0);
        checkOutput("post_rst_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
